// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: operation codes and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One narrow shift stage: moves acc by amt (0..STEP) positions per op.
// Rotate-right support for op 11 is built only when SHIFT_SEQ_ROTATE_EN is defined;
// otherwise op 11 passes acc through unchanged.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] shifted
);

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam int SHW = $clog2(WIDTH);
  // Left-shift distance that brings the bits falling off the right back in on the left.
  logic [SHW:0] back;
  assign back = (SHW + 1)'(WIDTH) - (SHW + 1)'(amt);
`endif

  // Select the partial shift for the current operation.
  always_comb begin
    shifted = acc;
    case (op)
      OP_SLL:  shifted = acc << amt;
      OP_SRL:  shifted = acc >> amt;
      OP_SRA:  shifted = $signed(acc) >>> amt;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  shifted = (acc >> amt) | (acc << back);
`else
      OP_ROR:  shifted = acc;
`endif
      default: shifted = acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: accepts one shift request, iterates it through
// a STEP-wide shift stage, and presents the result until the consumer takes it.
// Optional macro SHIFT_SEQ_ROTATE_EN turns op 11 into rotate-right; without it
// op 11 is a single-cycle pass-through of the operand.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [31:0]      in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int AW  = $clog2(STEP) + 1;
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [SHW-1:0]   rem;
  logic [1:0]       op;
  logic [SHW:0]     rem_ext;
  logic [SHW:0]     amt_ext;
  logic [AW-1:0]    amt;
  logic             accept;
  logic             last_step;
  logic             direct_done;
  logic             unused_shamt;

  // Only the low SHW shamt bits matter: shifts are taken modulo WIDTH.
  assign unused_shamt = ^in_shamt[31:SHW];

  assign rem_ext   = {1'b0, rem};
  assign amt_ext   = (rem_ext < STEP_W) ? rem_ext : STEP_W;
  assign amt       = amt_ext[AW-1:0];
  assign last_step = (rem_ext <= STEP_W);
  assign accept    = in_valid && (state == ST_IDLE);

`ifdef SHIFT_SEQ_ROTATE_EN
  assign direct_done = (in_shamt[SHW-1:0] == '0);
`else
  assign direct_done = (in_shamt[SHW-1:0] == '0) || (in_op == OP_ROR);
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc     (acc),
    .op      (op),
    .amt     (amt),
    .shifted (acc_step)
  );

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs decoded from the registered state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = direct_done ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one partial shift per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      rem <= '0;
      op  <= '0;
    end else if (accept) begin
      acc <= in_data;
      op  <= in_op;
      rem <= in_shamt[SHW-1:0];
    end else if (state == ST_SHIFT) begin
      acc <= acc_step;
      rem <= SHW'(rem_ext - amt_ext);
    end
  end

  assign out_data = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer (WIDTH=32, STEP=4).
// Expected results follow SHIFT_SEQ_ROTATE_EN when it is defined for the build.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [31:0] in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one request (called 1 time unit after a rising edge while idle),
  // then wait for out_valid. lat = 1 means valid right after the accepting edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s,
                        output logic [31:0] res, output int lat);
    in_op    = o;
    in_data  = d;
    in_shamt = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 00000000", out_data); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    logic [31:0] res;
    int lat;
    run_op(2'b00, 32'h0000_0001, 32'd5, res, lat);
    total_cnt++; if (res !== 32'h0000_0020) $display("FAIL sll5_data got %h want 00000020", res); else pass_cnt++;
    total_cnt++; if (lat !== 3) $display("FAIL sll5_latency got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sll5_busy_done got %b want 1", busy); else pass_cnt++;
    handoff();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL sll5_idle_after got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_sra_srl_max();
    logic [31:0] res;
    int lat;
    run_op(2'b10, 32'h8000_0000, 32'd31, res, lat);
    total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL sra31_data got %h want ffffffff", res); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL sra31_latency got %0d want 9", lat); else pass_cnt++;
    handoff();
    run_op(2'b01, 32'h8000_0000, 32'd31, res, lat);
    total_cnt++; if (res !== 32'h0000_0001) $display("FAIL srl31_data got %h want 00000001", res); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL srl31_latency got %0d want 9", lat); else pass_cnt++;
    handoff();
    run_op(2'b10, 32'h7000_00F0, 32'd6, res, lat);
    total_cnt++; if (res !== 32'h01C0_0003) $display("FAIL sra6_pos_data got %h want 01c00003", res); else pass_cnt++;
    handoff();
  endtask

  task automatic test_mod_and_zero();
    logic [31:0] res;
    int lat;
    run_op(2'b01, 32'h8000_0000, 32'd36, res, lat);
    total_cnt++; if (res !== 32'h0800_0000) $display("FAIL srl36_data got %h want 08000000", res); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL srl36_latency got %0d want 2", lat); else pass_cnt++;
    handoff();
    run_op(2'b00, 32'hDEAD_BEEF, 32'd0, res, lat);
    total_cnt++; if (res !== 32'hDEAD_BEEF) $display("FAIL shamt0_data got %h want deadbeef", res); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL shamt0_latency got %0d want 1", lat); else pass_cnt++;
    handoff();
    run_op(2'b00, 32'h0000_0001, 32'h0000_0120, res, lat);
    total_cnt++; if (res !== 32'h0000_0001) $display("FAIL shamt288_data got %h want 00000001", res); else pass_cnt++;
    total_cnt++; if (lat !== 1) $display("FAIL shamt288_latency got %0d want 1", lat); else pass_cnt++;
    handoff();
  endtask

  task automatic test_back_pressure();
    logic [31:0] res;
    int lat;
    run_op(2'b00, 32'h0000_0003, 32'd2, res, lat);
    total_cnt++; if (res !== 32'h0000_000C) $display("FAIL bp_first_data got %h want 0000000c", res); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_op = 2'b01; in_data = 32'h0000_00F0; in_shamt = 32'd4; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++; if (out_data !== 32'h0000_000C) $display("FAIL bp_hold_data cycle %0d got %h want 0000000c", i, out_data); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid); else pass_cnt++;
    end
    handoff();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_idle got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else pass_cnt++;
    run_op(2'b01, 32'h0000_00F0, 32'd4, res, lat);
    total_cnt++; if (res !== 32'h0000_000F) $display("FAIL bp_second_data got %h want 0000000f", res); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL bp_second_latency got %0d want 2", lat); else pass_cnt++;
    handoff();
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    int lat;
    in_op = 2'b10; in_data = 32'h8000_0000; in_shamt = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL mid_rst_out_data got %h want 00000000", out_data); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_no_pulse got %b want 0", out_valid); else pass_cnt++;
    end
    run_op(2'b00, 32'h0000_0001, 32'd1, res, lat);
    total_cnt++; if (res !== 32'h0000_0002) $display("FAIL post_rst_data got %h want 00000002", res); else pass_cnt++;
    total_cnt++; if (lat !== 2) $display("FAIL post_rst_latency got %0d want 2", lat); else pass_cnt++;
    handoff();
  endtask

  task automatic test_op11();
    logic [31:0] res;
    logic [31:0] exp_data;
    int lat;
    int exp_lat;
`ifdef SHIFT_SEQ_ROTATE_EN
    exp_data = 32'h8000_0000;
    exp_lat  = 2;
`else
    exp_data = 32'h0000_0001;
    exp_lat  = 1;
`endif
    run_op(2'b11, 32'h0000_0001, 32'd1, res, lat);
    total_cnt++; if (res !== exp_data) $display("FAIL op11_data got %h want %h", res, exp_data); else pass_cnt++;
    total_cnt++; if (lat !== exp_lat) $display("FAIL op11_latency got %0d want %0d", lat, exp_lat); else pass_cnt++;
    handoff();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = 32'h0;
    in_shamt  = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl_max();
    test_mod_and_zero();
    test_back_pressure();
    test_reset_mid_shift();
    test_op11();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
